mod_add_seq: RTL
================

MOD_ADD_SEQ -- requirements
Module: mod_add_seq

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 start  input  1  one-cycle request pulse; sampled only in IDLE.
REQ-005 subtract  input  1  0 = (a+b) mod m, 1 = (a-b) mod m; sampled with start.
REQ-006 in_a, in_b, in_m  input  384 each  operands and modulus; sampled with start.
REQ-007 result  output  384  modular result; held until the next accepted start.
REQ-008 done  output  1  one-cycle pulse; result is valid in the same cycle.
REQ-009 busy  output  1  high from the cycle after an accepted start until the cycle done pulses.

Function
REQ-010 SHALL capture a, b, m and subtract into internal registers on an accepted start; later input changes have no effect on the running operation.
REQ-011 SHALL hold operands 0 <= a, b < m, with m > 1; results for out-of-range operands are undefined.
REQ-012 SHALL use FSM states IDLE -> OP1_GO -> OP1_WAIT -> OP2_GO -> OP2_WAIT -> FIN -> IDLE.
REQ-013 OP1_GO, OP2_GO: assert the adder start for exactly one cycle, with the adder operands and subtract held stable until the adder done.
REQ-014 OP1_WAIT, OP2_WAIT: remain in the state until the adder done is high; latch the 385-bit adder result on the first cycle it is high.
REQ-015 Add path, op1: s = a + b (385 bits).
REQ-016 Add path, op2: d = s[383:0] - m.
REQ-017 Add path, select: result = d[383:0] if s[384]=1 or d[384]=0, else s[383:0].
REQ-018 Sub path, op1: d = a - b, with borrow = d[384].
REQ-019 Sub path, op2: e = d[383:0] + m.
REQ-020 Sub path, select: result = e[383:0] if borrow=1, else d[383:0].
REQ-021 SHALL always perform exactly two adder operations, so latency depends only on adder latency and not on data.
REQ-022 Latency: done pulses exactly 1 cycle after the op2 result is latched (in FIN); total latency = 2 + L1 + 2 + L2 + 1 cycles after start, where L1 and L2 are the adder latencies.
REQ-023 start while busy SHALL be ignored: no restart and no change to the captured operands.
REQ-024 start in the same cycle as FIN SHALL be ignored; a new start is accepted from IDLE, one cycle after done.
REQ-025 result SHALL update only in FIN.

Reset
REQ-026 Asserting reset SHALL force IDLE, result=0, done=0, busy=0, and clear the operand registers.
REQ-027 Reset mid-operation SHALL abort the operation; the internal adder is held in reset by the same signal, inverted to the adder's active-low resetn.
REQ-028 After reset is released, the first start in IDLE SHALL be accepted normally.

Structure
REQ-029 A shared package SHALL hold the constant OP_W = 384 and the FSM state enumeration.
REQ-030 SHALL instantiate exactly one sub-module: the team's existing multi-cycle adder (start/subtract/in_a/in_b -> result[384:0]/done).
REQ-031 The operand select multiplexers and the final result select SHALL be registered logic local to mod_add_seq.

Verification
REQ-032 Add, in_m=7, a=3, b=5 -> result=1, done for exactly one cycle, busy low afterwards.
REQ-033 Add, in_m=7, a=2, b=3 -> result=5 (no reduction).
REQ-034 Sub, in_m=7, a=2, b=5 -> result=4 (borrow path).
REQ-035 Sub, in_m=7, a=5, b=5 -> result=0.
REQ-036 Add, in_m=2^384-1, a=b=2^384-2 -> result=2^384-3 (s[384]=1 path).
REQ-037 Bench SHALL cover the control corners: reset asserted during OP1_WAIT -> result=0, busy=0, no done pulse; a second start during busy -> ignored, and the first operation's result is unchanged.

Source files
------------

// File: rtl/mod_add_seq_pkg.sv
// mod_add_seq_pkg: shared operand width, adder chunking and FSM encoding
// for the 384-bit sequential modular adder/subtractor.
package mod_add_seq_pkg;
    localparam int OP_W    = 384;
    localparam int CHUNK_W = 64;
    localparam int N_CHUNK = OP_W / CHUNK_W;
    typedef enum logic [2:0] {IDLE, OP1_GO, OP1_WAIT, OP2_GO, OP2_WAIT, FIN} state_e;
endpackage

// File: rtl/mod_add_seq_adder.sv
// mod_add_seq_adder: multi-cycle 384-bit adder/subtractor, one 64-bit chunk per
// cycle; result[384] is the carry for add and the borrow for subtract.
module mod_add_seq_adder
    import mod_add_seq_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            subtract,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    output logic [OP_W:0]   result,
    output logic            done
);
    localparam int IDX_W = $clog2(N_CHUNK);
    logic [OP_W-1:0]  a_q, b_q;
    logic [OP_W:0]    acc_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q, sub_q, carry_q, done_q;
    logic [CHUNK_W:0] sum;
    assign sum = {1'b0, a_q[int'(idx_q) * CHUNK_W +: CHUNK_W]}
               + {1'b0, b_q[int'(idx_q) * CHUNK_W +: CHUNK_W]}
               + {{CHUNK_W{1'b0}}, carry_q};
    // Subtraction is a + ~b + 1, so the final carry-out is the inverted borrow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q && start) begin
                a_q     <= in_a;
                b_q     <= subtract ? ~in_b : in_b;
                sub_q   <= subtract;
                carry_q <= subtract;
                idx_q   <= '0;
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                acc_q[int'(idx_q) * CHUNK_W +: CHUNK_W] <= sum[CHUNK_W-1:0];
                carry_q <= sum[CHUNK_W];
                idx_q   <= idx_q + 1'b1;
                if (idx_q == IDX_W'(N_CHUNK - 1)) begin
                    acc_q[OP_W] <= sum[CHUNK_W] ^ sub_q;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                end
            end
        end
    end
    assign result = acc_q;
    assign done   = done_q;
endmodule

// File: rtl/mod_add_seq.sv
// mod_add_seq: (a+b) mod m or (a-b) mod m using two passes through one shared
// multi-cycle adder; always two passes so latency is data independent.
module mod_add_seq
    import mod_add_seq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            subtract,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    input  logic [OP_W-1:0] in_m,
    output logic [OP_W-1:0] result,
    output logic            done,
    output logic            busy
);
    state_e          state_q, state_d;
    logic [OP_W-1:0] add_a_q, add_a_d, add_b_q, add_b_d, m_q, m_d, result_q, result_d;
    logic [OP_W:0]   s_q, s_d, add_res;
    logic            add_sub_q, add_sub_d, sub_q, sub_d, add_start, add_done;
    mod_add_seq_adder u_adder (
        .clk      (clk),
        .resetn   (~reset),
        .start    (add_start),
        .subtract (add_sub_q),
        .in_a     (add_a_q),
        .in_b     (add_b_q),
        .result   (add_res),
        .done     (add_done)
    );
    always_comb begin
        state_d   = state_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_sub_d = add_sub_q;
        sub_d     = sub_q;
        m_d       = m_q;
        s_d       = s_q;
        result_d  = result_q;
        add_start = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                add_a_d   = in_a;
                add_b_d   = in_b;
                add_sub_d = subtract;
                sub_d     = subtract;
                m_d       = in_m;
                state_d   = OP1_GO;
            end
            OP1_GO: begin
                add_start = 1'b1;
                state_d   = OP1_WAIT;
            end
            // Second pass corrects the first: subtract m after an add, add m after a subtract.
            OP1_WAIT: if (add_done) begin
                s_d       = add_res;
                add_a_d   = add_res[OP_W-1:0];
                add_b_d   = m_q;
                add_sub_d = ~sub_q;
                state_d   = OP2_GO;
            end
            OP2_GO: begin
                add_start = 1'b1;
                state_d   = OP2_WAIT;
            end
            OP2_WAIT: if (add_done) begin
                result_d = sub_q ? (s_q[OP_W] ? add_res[OP_W-1:0] : s_q[OP_W-1:0])
                                 : ((s_q[OP_W] || !add_res[OP_W]) ? add_res[OP_W-1:0] : s_q[OP_W-1:0]);
                state_d  = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_sub_q <= 1'b0;
            sub_q     <= 1'b0;
            m_q       <= '0;
            s_q       <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_sub_q <= add_sub_d;
            sub_q     <= sub_d;
            m_q       <= m_d;
            s_q       <= s_d;
            result_q  <= result_d;
        end
    end
    assign result = result_q;
    assign done   = state_q == FIN;
    assign busy   = state_q != IDLE && state_q != FIN;
endmodule
